// File: rtl/minimax_mmio_monitor.sv
// Memory-mapped monitor for the minimax data bus: console FIFO, exit register,
// free-running tick counter and watchdog, all decoded from one 32-byte window.
module minimax_mmio_monitor #(
    parameter logic [31:0] BASE       = 32'hFFFFFFE0,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAXTICKS   = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rreq,
    output logic [31:0] rdata,
    output logic [31:0] con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        done,
    output logic [31:0] exit_code,
    output logic        timeout,
    output logic        dbg_state_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;

    localparam logic [4:0] OFF_TICKS   = 5'h10;
    localparam logic [4:0] OFF_STATUS  = 5'h14;
    localparam logic [4:0] OFF_CONSOLE = 5'h18;
    localparam logic [4:0] OFF_EXIT    = 5'h1C;

    localparam logic        WD_EN    = (MAXTICKS != 0);
    localparam logic [31:0] WD_LIMIT = (MAXTICKS == 0) ? 32'd0 : 32'(MAXTICKS - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic hit;
    logic wr;
    logic con_wr;
    logic exit_wr;

    assign hit     = (addr[31:5] == BASE[31:5]);
    assign wr      = hit && (wmask == 4'hf);
    assign con_wr  = wr && (addr[4:0] == OFF_CONSOLE);
    assign exit_wr = wr && (addr[4:0] == OFF_EXIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic        timeout_q, timeout_d;
    logic [31:0] ticks_q, ticks_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ovf_q, ovf_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic fifo_empty;
    logic fifo_full;
    logic push_req;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Tick counter (saturating, keeps running after done)
    // ------------------------------------------------------------------
    always_comb begin
        ticks_d = ticks_q;
        if (ticks_q != 32'hFFFFFFFF) begin
            ticks_d = ticks_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // Stream handshake: a word transfers on any cycle where con_valid and
    // con_ready are both high; con_data holds the head until that happens.
    // ------------------------------------------------------------------
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && con_ready;
    assign push_req   = con_wr && (state_q == S_RUN);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Storage carries no reset; the level counter alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign con_valid = !fifo_empty;
    assign con_data  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Run/done state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_RUN: begin
                if (exit_wr) begin
                    state_d     = S_DONE;
                    exit_code_d = wdata;
                    timeout_d   = 1'b0;
                end else if (WD_EN && (ticks_q >= WD_LIMIT)) begin
                    state_d     = S_DONE;
                    exit_code_d = 32'hFFFFFFFF;
                    timeout_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register read path (value as of the request cycle)
    // ------------------------------------------------------------------
    logic [31:0] status_w;
    logic [31:0] rd_val;

    assign status_w = {ovf_q, 13'd0, fifo_full, fifo_empty, 16'(level_q)};

    always_comb begin
        rd_val = 32'd0;
        case (addr[4:0])
            OFF_TICKS:  rd_val = ticks_q;
            OFF_STATUS: rd_val = status_w;
            default:    rd_val = 32'd0;
        endcase
        rdata_d = (rreq && hit) ? rd_val : 32'd0;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            exit_code_q <= 32'd0;
            timeout_q   <= 1'b0;
            ticks_q     <= 32'd0;
            rdata_q     <= 32'd0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
            timeout_q   <= timeout_d;
            ticks_q     <= ticks_d;
            rdata_q     <= rdata_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    assign rdata       = rdata_q;
    assign done        = (state_q == S_DONE);
    assign exit_code   = exit_code_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_minimax_mmio_monitor.sv
// Directed bench for minimax_mmio_monitor: a per-cycle vector table for the
// basic register/console paths plus hand-written multi-cycle scenarios.
module tb_minimax_mmio_monitor;

    localparam logic [31:0] BASE    = 32'hFFFFFFE0;
    localparam logic [31:0] A_TICKS = BASE + 32'h10;
    localparam logic [31:0] A_STAT  = BASE + 32'h14;
    localparam logic [31:0] A_CONS  = BASE + 32'h18;
    localparam logic [31:0] A_EXIT  = BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rreq;
    logic [31:0] rdata;
    logic [31:0] con_data;
    logic        con_valid;
    logic        con_ready;
    logic        done;
    logic [31:0] exit_code;
    logic        timeout;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    minimax_mmio_monitor #(
        .BASE      (BASE),
        .FIFO_DEPTH(8),
        .MAXTICKS  (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .wmask      (wmask),
        .rreq       (rreq),
        .rdata      (rdata),
        .con_data   (con_data),
        .con_valid  (con_valid),
        .con_ready  (con_ready),
        .done       (done),
        .exit_code  (exit_code),
        .timeout    (timeout),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rreq;
        logic        con_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        addr  = 32'd0;
        wdata = 32'd0;
        wmask = 4'h0;
        rreq  = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        con_ready = 1'b0;
        set_idle();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wmask = 4'hf;
        rreq  = 1'b0;
        cycle();
        set_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rreq = 1'b1;
        cycle();
        d = rdata;
        set_idle();
    endtask

    logic [31:0] rd;

    initial begin
        // rows are applied one per cycle straight after reset (ticks start at 0)
        vecs[0]  = '{A_CONS,       32'h11, 4'hf, 1'b0, 1'b1, 1'b1, 32'h11, 32'h0};
        vecs[1]  = '{A_CONS,       32'h22, 4'hf, 1'b0, 1'b1, 1'b1, 32'h22, 32'h0};
        vecs[2]  = '{A_CONS,       32'h33, 4'hf, 1'b0, 1'b1, 1'b1, 32'h33, 32'h0};
        vecs[3]  = '{32'h0,        32'h0,  4'h0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[4]  = '{A_TICKS,      32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  32'd4};
        vecs[5]  = '{A_STAT,       32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h00010000};
        vecs[6]  = '{A_CONS,       32'h44, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[7]  = '{32'hFFFFFFD8, 32'h66, 4'hf, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[8]  = '{A_CONS,       32'h55, 4'hf, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0};
        vecs[9]  = '{A_STAT,       32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 32'h55, 32'h00000001};
        vecs[10] = '{BASE,         32'h0,  4'h0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
        vecs[11] = '{32'hFFFFFFD0, 32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[12] = '{A_TICKS,      32'h0,  4'hf, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        vecs[13] = '{A_TICKS,      32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0,  32'd13};

        // ---------------- reset values ----------------
        do_reset();
        check("rst_rdata",     rdata,     32'h0);
        check("rst_con_valid", 32'(con_valid), 32'h0);
        check("rst_con_data",  con_data,  32'h0);
        check("rst_done",      32'(done), 32'h0);
        check("rst_exit_code", exit_code, 32'h0);
        check("rst_timeout",   32'(timeout), 32'h0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 14; i++) begin
            addr      = vecs[i].addr;
            wdata     = vecs[i].wdata;
            wmask     = vecs[i].wmask;
            rreq      = vecs[i].rreq;
            con_ready = vecs[i].con_ready;
            cycle();
            check($sformatf("vec%0d_valid", i), 32'(con_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i),  con_data, vecs[i].exp_data);
            check($sformatf("vec%0d_rdata", i), rdata,    vecs[i].exp_rdata);
            check($sformatf("vec%0d_done", i),  32'(done), 32'h0);
        end
        set_idle();

        // ---------------- overflow: 9 pushes into depth 8 ----------------
        do_reset();
        for (int i = 0; i < 9; i++) bus_write(A_CONS, 32'(i + 1));
        check("ovf_head", con_data, 32'd1);
        bus_read(A_STAT, rd);
        check("ovf_status", rd, 32'h80020008);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), con_data, 32'(i + 1));
            cycle();
        end
        check("ovf_empty_after", 32'(con_valid), 32'h0);
        bus_read(A_STAT, rd);
        check("ovf_sticky", rd, 32'h80010000);

        // ---------------- full FIFO push+pop same cycle ----------------
        do_reset();
        for (int i = 0; i < 8; i++) bus_write(A_CONS, 32'hA0 + 32'(i));
        con_ready = 1'b1;
        bus_write(A_CONS, 32'hA8);
        con_ready = 1'b0;
        bus_read(A_STAT, rd);
        check("pp_status", rd, 32'h00020008);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_drain%0d", i), con_data, 32'hA1 + 32'(i));
            cycle();
        end
        check("pp_empty_after", 32'(con_valid), 32'h0);
        con_ready = 1'b0;

        // ---------------- exit at tick 50 ----------------
        do_reset();
        idle(50);
        bus_write(A_EXIT, 32'h0);
        check("exit_done",    32'(done), 32'h1);
        check("exit_code",    exit_code, 32'h0);
        check("exit_timeout", 32'(timeout), 32'h0);
        check("exit_dbg",     32'(dbg_state), 32'h1);
        bus_write(A_EXIT, 32'h5);
        check("exit_ignored", exit_code, 32'h0);
        bus_write(A_CONS, 32'h77);
        check("exit_cons_ignored", 32'(con_valid), 32'h0);
        bus_read(A_TICKS, rd);
        check("exit_ticks_run", rd, 32'd53);
        idle(60);
        check("exit_no_wd_timeout", 32'(timeout), 32'h0);
        check("exit_no_wd_code",    exit_code, 32'h0);

        // ---------------- watchdog fires on cycle 100 ----------------
        do_reset();
        idle(99);
        check("wd_not_yet", 32'(done), 32'h0);
        cycle();
        check("wd_done",    32'(done), 32'h1);
        check("wd_timeout", 32'(timeout), 32'h1);
        check("wd_code",    exit_code, 32'hFFFFFFFF);

        // ---------------- exit and watchdog in the same cycle ----------------
        do_reset();
        idle(99);
        bus_write(A_EXIT, 32'h1234);
        check("tie_done",    32'(done), 32'h1);
        check("tie_code",    exit_code, 32'h1234);
        check("tie_timeout", 32'(timeout), 32'h0);

        // ---------------- reset mid-operation ----------------
        do_reset();
        for (int i = 0; i < 5; i++) bus_write(A_CONS, 32'hC0 + 32'(i));
        bus_write(A_EXIT, 32'h9);
        check("mid_pre_done",  32'(done), 32'h1);
        check("mid_pre_valid", 32'(con_valid), 32'h1);
        reset = 1'b1;
        cycle();
        check("mid_valid",   32'(con_valid), 32'h0);
        check("mid_done",    32'(done), 32'h0);
        check("mid_code",    exit_code, 32'h0);
        check("mid_timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        bus_read(A_TICKS, rd);
        check("mid_ticks", rd, 32'h0);
        bus_read(A_STAT, rd);
        check("mid_status", rd, 32'h00010000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
